// File: rtl/regfile_dump_bypass_pkg.sv
// cpu_regfile_pkg: shared defaults and dump-engine state encoding for the decode-stage register file.
package cpu_regfile_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam bit ZERO_REG_DEF = 1'b1;
    localparam bit BYPASS_DEF   = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;
endpackage

// File: rtl/regfile_dump_bypass_if.sv
// regfile_dump_bypass_if: read/write ports and debug dump stream of the register file.
interface regfile_dump_bypass_if
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              hold;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              dbg_start;
    logic              dbg_ready;
    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_busy;
    logic              dbg_done;
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, hold, dbg_start, dbg_ready,
        input  rd_data_a, rd_data_b, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, hold, dbg_start, dbg_ready,
        output rd_data_a, rd_data_b, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
    );
endinterface

// File: rtl/regfile_dump_bypass_fsm.sv
// regfile_dump_fsm: walks every register out through the valid/ready debug port, one word per two cycles.
module regfile_dump_fsm
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_start_i,
    input  logic              dbg_ready_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              dbg_valid_o,
    output logic [ADDR_W-1:0] dbg_addr_o,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              dbg_busy_o,
    output logic              dbg_done_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'((2 ** ADDR_W) - 1);

    dump_state_e       state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              valid_q, busy_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign rd_addr_o   = idx_q;
    assign dbg_valid_o = valid_q;
    assign dbg_addr_o  = addr_q;
    assign dbg_data_o  = data_q;
    assign dbg_busy_o  = busy_q;
    assign dbg_done_o  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (dbg_start_i) begin
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: begin
                    data_q  <= rd_word_i;
                    addr_q  <= idx_q;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: if (dbg_ready_i) begin
                    valid_q <= 1'b0;
                    if (idx_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= LOAD;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/regfile_dump_bypass.sv
// regfile_dump_bypass: 2R/1W register file with write-first bypass, optional zero register and debug dump.
module regfile_dump_bypass
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF,
    parameter bit BYPASS   = BYPASS_DEF
) (
    input logic clk,
    input logic rst,
    regfile_dump_bypass_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_a_q, rd_b_q, rd_a_d, rd_b_d, dbg_word;
    logic [ADDR_W-1:0] dbg_idx;

    // Zero register wins over the bypass so reg 0 can never leak a dropped write.
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        return (ZERO_REG && a == '0) ? '0 :
               (BYPASS && bus.wr_en && bus.wr_addr == a) ? bus.wr_data : mem_q[a];
    endfunction

    always_comb begin
        rd_a_d   = rd_word(bus.rd_addr_a);
        rd_b_d   = rd_word(bus.rd_addr_b);
        dbg_word = rd_word(dbg_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (bus.wr_en && !(ZERO_REG && bus.wr_addr == '0)) mem_q[bus.wr_addr] <= bus.wr_data;
            if (!bus.hold) begin
                rd_a_q <= rd_a_d;
                rd_b_q <= rd_b_d;
            end
        end
    end

    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;

    regfile_dump_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .dbg_start_i (bus.dbg_start),
        .dbg_ready_i (bus.dbg_ready),
        .rd_word_i   (dbg_word),
        .rd_addr_o   (dbg_idx),
        .dbg_valid_o (bus.dbg_valid),
        .dbg_addr_o  (bus.dbg_addr),
        .dbg_data_o  (bus.dbg_data),
        .dbg_busy_o  (bus.dbg_busy),
        .dbg_done_o  (bus.dbg_done)
    );
endmodule

// File: tb/tb_regfile_dump_bypass.sv
// tb_regfile_dump_bypass: scoreboard bench for the default build and a ZERO_REG=0/BYPASS=0 build side by side.
module tb_regfile_dump_bypass;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_dump_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
    regfile_dump_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

    assign b1.wr_en     = b0.wr_en;
    assign b1.wr_addr   = b0.wr_addr;
    assign b1.wr_data   = b0.wr_data;
    assign b1.rd_addr_a = b0.rd_addr_a;
    assign b1.rd_addr_b = b0.rd_addr_b;
    assign b1.hold      = b0.hold;
    assign b1.dbg_start = b0.dbg_start;
    assign b1.dbg_ready = b0.dbg_ready;

    regfile_dump_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );
    regfile_dump_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_alt (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct packed {
        logic [DW-1:0] a0, b0, a1, b1;
    } rexp_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d0, d1;
    } beat_t;

    rexp_t rq[$];
    beat_t dq[$];
    logic [DW-1:0] m0[DEPTH];
    logic [DW-1:0] m1[DEPTH];
    logic [DW-1:0] ea0, eb0, ea1, eb1;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
    endtask

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic h);
        rexp_t e;
        b0.wr_en = we; b0.wr_addr = wa; b0.wr_data = wd;
        b0.rd_addr_a = ra; b0.rd_addr_b = rb; b0.hold = h;
        if (!h) begin
            ea0 = (ra == 0) ? '0 : (we && wa == ra) ? wd : m0[ra];
            eb0 = (rb == 0) ? '0 : (we && wa == rb) ? wd : m0[rb];
            ea1 = m1[ra];
            eb1 = m1[rb];
        end
        rq.push_back('{ea0, eb0, ea1, eb1});
        if (we) begin
            if (wa != 0) m0[wa] = wd;
            m1[wa] = wd;
        end
        cyc();
        e = rq.pop_front();
        chk("rd_a", b0.rd_data_a, e.a0);
        chk("rd_b", b0.rd_data_b, e.b0);
        chk("alt_rd_a", b1.rd_data_a, e.a1);
        chk("alt_rd_b", b1.rd_data_b, e.b1);
    endtask

    task automatic chk_dbg_idle(input string tag);
        chk({tag, "_valid"}, DW'(b0.dbg_valid), '0);
        chk({tag, "_addr"}, DW'(b0.dbg_addr), '0);
        chk({tag, "_data"}, b0.dbg_data, '0);
        chk({tag, "_busy"}, DW'(b0.dbg_busy), '0);
        chk({tag, "_done"}, DW'(b0.dbg_done), '0);
    endtask

    initial begin
        beat_t bt;
        int done_n, stall;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        rst = 1'b1;
        b0.wr_en = 0; b0.wr_addr = 0; b0.wr_data = 0; b0.rd_addr_a = 0; b0.rd_addr_b = 0;
        b0.hold = 0; b0.dbg_start = 0; b0.dbg_ready = 0;
        cyc(); cyc();
        rst = 1'b0;
        model_reset();
        chk("reset_rd_a", b0.rd_data_a, '0);
        chk("reset_rd_b", b0.rd_data_b, '0);
        chk_dbg_idle("reset");

        step(1, 5, 32'hDEADBEEF, 5, 5, 0);
        rst = 1'b1; b0.wr_en = 0;
        cyc();
        rst = 1'b0;
        model_reset();
        chk_dbg_idle("rst2");
        step(0, 0, 0, 5, 5, 0);

        step(1, 7, 32'hAAAA5555, 1, 2, 0);
        step(1, 7, 32'h12345678, 7, 7, 0);
        step(0, 0, 0, 7, 7, 0);

        step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 3, 32'h11, 0, 0, 0);
        step(0, 0, 0, 3, 3, 0);
        for (int k = 0; k < 3; k++) step(1, 3, 32'h99 + DW'(k), AW'(k + 4), AW'(k + 8), 1);
        step(0, 0, 0, 3, 3, 0);

        for (int k = 0; k < 40; k++)
            step(1'($urandom_range(0, 1)), AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
                 1'($urandom_range(0, 3) == 0));

        for (int i = 0; i < DEPTH; i++) step(1, AW'(i), DW'(i * 3), AW'(i), 0, 0);
        step(0, 0, 0, 0, 0, 0);

        b0.dbg_start = 1;
        for (int i = 0; i < DEPTH; i++) dq.push_back('{AW'(i), m0[i], m1[i]});
        cyc();
        b0.dbg_start = 0;
        done_n = 0; stall = 0; ha = '0; hd = '0;
        for (int c = 0; c < 400; c++) begin
            if (b0.dbg_done) done_n++;
            if (stall != 0) begin
                chk("stall_valid", DW'(b0.dbg_valid), 1);
                chk("stall_addr", DW'(b0.dbg_addr), DW'(ha));
                chk("stall_data", b0.dbg_data, hd);
            end
            stall = 0;
            if (!b0.dbg_busy && done_n > 0) break;
            b0.dbg_ready = 1'($urandom_range(0, 1));
            b0.dbg_start = (c == 20);
            if (b0.dbg_valid) begin
                if (b0.dbg_ready) begin
                    if (dq.size() == 0) chk("extra_beat", 1, 0);
                    else begin
                        bt = dq.pop_front();
                        chk("dump_addr", DW'(b0.dbg_addr), DW'(bt.a));
                        chk("dump_data", b0.dbg_data, bt.d0);
                        chk("alt_dump_data", b1.dbg_data, bt.d1);
                    end
                end else begin
                    stall = 1; ha = b0.dbg_addr; hd = b0.dbg_data;
                end
            end
            cyc();
        end
        b0.dbg_start = 0;
        chk("beats_left", DW'(dq.size()), 0);
        chk("done_pulses", DW'(done_n), 1);
        chk("busy_after", DW'(b0.dbg_busy), 0);

        b0.dbg_ready = 1;
        b0.dbg_start = 1;
        cyc();
        b0.dbg_start = 0;
        for (int c = 0; c < 100; c++) begin
            if (b0.dbg_valid && b0.dbg_addr == 10) break;
            cyc();
        end
        chk("reach_word10", DW'(b0.dbg_addr), 10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        chk("midrst_valid", DW'(b0.dbg_valid), 0);
        chk("midrst_busy", DW'(b0.dbg_busy), 0);
        chk("midrst_rd_a", b0.rd_data_a, '0);
        b0.dbg_start = 1;
        cyc();
        b0.dbg_start = 0;
        for (int c = 0; c < 10; c++) begin
            if (b0.dbg_valid) break;
            cyc();
        end
        chk("restart_valid", DW'(b0.dbg_valid), 1);
        chk("restart_addr", DW'(b0.dbg_addr), 0);
        chk("restart_data", b0.dbg_data, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
